move_executor: RTL

Executes one cube move at a time for the sequencer: accepts a 4-bit move code on a start_move pulse and drives the step/dir pins of the six face stepper drivers for one quarter turn. After a settle delay it returns a one-cycle move_done pulse. It sits between the move sequencer and the stepper driver pins and owns all step timing.

---
 rtl/move_executor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/move_executor.sv
// Single-face quarter-turn executor: drives step/dir pins of six stepper drivers per move code.
// Optional MOVE_EXEC_RAMP_EN doubles the period of the first/last RAMP_STEPS steps.
module move_executor #(
  parameter int unsigned STEPS_PER_QUARTER = 50,
  parameter int unsigned STEP_PERIOD       = 2000,
  parameter int unsigned PULSE_WIDTH       = 200,
  parameter int unsigned DIR_SETUP         = 100,
  parameter int unsigned SETTLE_CYCLES     = 50000,
  parameter int unsigned RAMP_STEPS        = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_move,
  input  logic [3:0]  next_move,
  output logic        move_done,
  output logic        busy,
  output logic        bad_move,
  output logic        motor_en,
  output logic [5:0]  step,
  output logic [5:0]  dir,
  output logic [15:0] move_count
);

`ifdef MOVE_EXEC_RAMP_EN
  localparam int unsigned LO_MAX = 2 * STEP_PERIOD - PULSE_WIDTH;
`else
  localparam int unsigned LO_MAX = STEP_PERIOD - PULSE_WIDTH;
`endif
  localparam int unsigned MAX_A = (DIR_SETUP > PULSE_WIDTH) ? DIR_SETUP : PULSE_WIDTH;
  localparam int unsigned MAX_B = (LO_MAX > SETTLE_CYCLES) ? LO_MAX : SETTLE_CYCLES;
  localparam int unsigned TMAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam int unsigned SW    = $clog2(STEPS_PER_QUARTER + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STEP_HI = 3'd2;
  localparam logic [2:0] S_STEP_LO = 3'd3;
  localparam logic [2:0] S_SETTLE  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state;
  logic [2:0]    face;
  logic [TW-1:0] timer;
  logic [SW-1:0] step_cnt;
  logic [TW-1:0] lo_load;
  logic          legal;
  logic          cw;
  logic [2:0]    face_d;
  logic [5:0]    face_mask;

  always_comb begin
    legal  = 1'b0;
    cw     = 1'b0;
    face_d = '0;
    if (next_move >= 4'd1 && next_move <= 4'd6) begin
      legal  = 1'b1;
      cw     = 1'b1;
      face_d = 3'(next_move - 4'd1);
    end else if (next_move >= 4'd7 && next_move <= 4'd12) begin
      legal  = 1'b1;
      face_d = 3'(next_move - 4'd7);
    end
  end

  assign face_mask = 6'b000001 << face;

`ifdef MOVE_EXEC_RAMP_EN
  // Ramp steps keep the same high time; the extra period goes into the low phase.
  logic lo_long;
  assign lo_long = (32'(step_cnt) < RAMP_STEPS) ||
                   (32'(step_cnt) + RAMP_STEPS >= STEPS_PER_QUARTER);
  assign lo_load = lo_long ? TW'(2 * STEP_PERIOD - PULSE_WIDTH - 1)
                           : TW'(STEP_PERIOD - PULSE_WIDTH - 1);
`else
  logic unused_ramp;
  assign unused_ramp = |RAMP_STEPS;
  assign lo_load     = TW'(STEP_PERIOD - PULSE_WIDTH - 1);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      face       <= '0;
      timer      <= '0;
      step_cnt   <= '0;
      move_done  <= 1'b0;
      busy       <= 1'b0;
      bad_move   <= 1'b0;
      motor_en   <= 1'b0;
      step       <= '0;
      dir        <= '0;
      move_count <= '0;
    end else begin
      move_done <= 1'b0;
      bad_move  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_move) begin
            if (legal) begin
              face     <= face_d;
              dir      <= cw ? (6'b000001 << face_d) : '0;
              busy     <= 1'b1;
              motor_en <= 1'b1;
              timer    <= TW'(DIR_SETUP - 1);
              step_cnt <= '0;
              state    <= S_SETUP;
            end else begin
              move_done <= 1'b1;
              bad_move  <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (timer == '0) begin
            step  <= face_mask;
            timer <= TW'(PULSE_WIDTH - 1);
            state <= S_STEP_HI;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_STEP_HI: begin
          if (timer == '0) begin
            step  <= '0;
            timer <= lo_load;
            state <= S_STEP_LO;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_STEP_LO: begin
          if (timer == '0) begin
            if (step_cnt == SW'(STEPS_PER_QUARTER - 1)) begin
              step_cnt <= '0;
              timer    <= TW'(SETTLE_CYCLES - 1);
              state    <= S_SETTLE;
            end else begin
              step_cnt <= step_cnt + 1'b1;
              step     <= face_mask;
              timer    <= TW'(PULSE_WIDTH - 1);
              state    <= S_STEP_HI;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_SETTLE: begin
          if (timer == '0) begin
            move_done  <= 1'b1;
            busy       <= 1'b0;
            motor_en   <= 1'b0;
            dir        <= '0;
            move_count <= move_count + 1'b1;
            state      <= S_DONE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
